ifid_queue: RTL and testbench

//   Instruction queue between iFetch and decode. Buffers {nPC, IR} pairs produced by

---
 rtl/ifid_queue.sv | 89 ++++++++
 tb/tb_ifid_queue.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ifid_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of {nPC, IR}
// pairs with valid/ready on both sides and a flush that empties it in one cycle.
module ifid_queue #(
  parameter int DEPTH    = 4,
  parameter int WIDTH_PC = 64,
  parameter int WIDTH_IR = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_PC-1:0]        in_nPC,
  input  logic [WIDTH_IR-1:0]        in_IR,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_PC-1:0]        out_nPC,
  output logic [WIDTH_IR-1:0]        out_IR,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH_PC-1:0] npc_q [DEPTH];
  logic [WIDTH_PC-1:0] npc_d [DEPTH];
  logic [WIDTH_IR-1:0] ir_q  [DEPTH];
  logic [WIDTH_IR-1:0] ir_d  [DEPTH];
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                push, pop;

  // Ready depends on occupancy alone; a pop in a full cycle frees the slot next cycle.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_nPC   = out_valid ? npc_q[rd_ptr_q] : '0;
  assign out_IR    = out_valid ? ir_q[rd_ptr_q]  : '0;
  assign count     = count_q;

  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    npc_d    = npc_q;
    ir_d     = ir_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        npc_d[wr_ptr_q] = in_nPC;
        ir_d[wr_ptr_q]  = in_IR;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        npc_q[i] <= '0;
        ir_q[i]  <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      npc_q    <= npc_d;
      ir_q     <= ir_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_ifid_queue.sv
// Directed-vector bench for ifid_queue: a table of per-cycle inputs and the
// outputs expected after that clock edge, plus a short hand-written full/flush sequence.
module tb_ifid_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_nPC = '0;
  logic [31:0] in_IR = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_nPC;
  logic [31:0] out_IR;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  ifid_queue #(.DEPTH(4), .WIDTH_PC(64), .WIDTH_IR(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_nPC(in_nPC), .in_IR(in_IR),
    .out_valid(out_valid), .out_ready(out_ready), .out_nPC(out_nPC), .out_IR(out_IR),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        fl;
    logic        iv;
    logic [63:0] npc;
    logic [31:0] ir;
    logic        ordy;
    logic [2:0]  e_cnt;
    logic        e_ov;
    logic        e_irdy;
    logic [63:0] e_npc;
    logic [31:0] e_ir;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic r, logic f, logic iv, logic [63:0] npc, logic [31:0] ir,
                              logic ordy, logic [2:0] c, logic ov, logic irdy,
                              logic [63:0] onpc, logic [31:0] oir);
    vq.push_back('{r, f, iv, npc, ir, ordy, c, ov, irdy, onpc, oir});
  endfunction

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  function automatic logic [63:0] p_npc(int k); return 64'h2000 + 64'(4 * k); endfunction
  function automatic logic [31:0] p_ir(int k);  return 32'h9100_0000 + 32'(k); endfunction
  function automatic logic [63:0] s_npc(int k); return 64'h3000 + 64'(4 * k); endfunction
  function automatic logic [31:0] s_ir(int k);  return 32'hA000_0000 + 32'(k); endfunction

  initial begin
    // reset held two cycles
    add(0,0,0,0,0,0, 0,0,1,0,0);
    add(0,0,0,0,0,0, 0,0,1,0,0);
    // fill with decode stalled, then a push attempt while full
    add(1,0,1,64'h1000,32'h8B020020,0, 1,1,1,64'h1000,32'h8B020020);
    add(1,0,1,64'h1004,32'h8B030041,0, 2,1,1,64'h1000,32'h8B020020);
    add(1,0,1,64'h1008,32'hD1000442,0, 3,1,1,64'h1000,32'h8B020020);
    add(1,0,1,64'h100C,32'hF8000003,0, 4,1,0,64'h1000,32'h8B020020);
    add(1,0,1,64'h1010,32'hDEADBEEF,0, 4,1,0,64'h1000,32'h8B020020);
    // full: push refused, pop accepted
    add(1,0,1,64'h1010,32'hDEADBEEF,1, 3,1,1,64'h1004,32'h8B030041);
    add(1,0,0,0,0,1, 2,1,1,64'h1008,32'hD1000442);
    add(1,0,0,0,0,1, 1,1,1,64'h100C,32'hF8000003);
    add(1,0,0,0,0,1, 0,0,1,0,0);
    add(1,0,0,0,0,1, 0,0,1,0,0);
    // six pushes / six pops, both pointers wrap
    for (int k = 0; k < 3; k++) add(1,0,1,p_npc(k),p_ir(k),0, 3'(k+1),1,1,p_npc(0),p_ir(0));
    for (int k = 3; k < 6; k++) add(1,0,1,p_npc(k),p_ir(k),1, 3,1,1,p_npc(k-2),p_ir(k-2));
    add(1,0,0,0,0,1, 2,1,1,p_npc(4),p_ir(4));
    add(1,0,0,0,0,1, 1,1,1,p_npc(5),p_ir(5));
    add(1,0,0,0,0,1, 0,0,1,0,0);
    // streaming at count=1
    add(1,0,1,s_npc(0),s_ir(0),0, 1,1,1,s_npc(0),s_ir(0));
    for (int k = 1; k < 6; k++) add(1,0,1,s_npc(k),s_ir(k),1, 1,1,1,s_npc(k),s_ir(k));
    // flush at count=3 with push and pop requested
    add(1,0,1,64'h5000,32'hB0000000,0, 2,1,1,s_npc(5),s_ir(5));
    add(1,0,1,64'h5004,32'hB0000001,0, 3,1,1,s_npc(5),s_ir(5));
    add(1,1,1,64'h5008,32'hB0000002,1, 0,0,1,0,0);
    add(1,0,1,64'h6000,32'hC0000000,0, 1,1,1,64'h6000,32'hC0000000);
    // reset mid-stream at count=2
    add(1,0,1,64'h6004,32'hC0000001,0, 2,1,1,64'h6000,32'hC0000000);
    add(0,0,1,64'h6008,32'hC0000002,1, 0,0,1,0,0);
    add(1,0,1,64'h7000,32'hD0000000,0, 1,1,1,64'h7000,32'hD0000000);
    // reset and flush together
    add(0,1,1,64'h7004,32'hD0000001,1, 0,0,1,0,0);
    add(1,0,1,64'h8000,32'hE0000000,0, 1,1,1,64'h8000,32'hE0000000);
    add(1,0,1,64'h8004,32'hE0000001,0, 2,1,1,64'h8000,32'hE0000000);
    add(1,0,1,64'h8008,32'hE0000002,0, 3,1,1,64'h8000,32'hE0000000);
    add(1,0,1,64'h800C,32'hE0000003,0, 4,1,0,64'h8000,32'hE0000000);

    foreach (vq[i]) begin
      @(negedge clk);
      reset     = vq[i].rst_n;
      flush     = vq[i].fl;
      in_valid  = vq[i].iv;
      in_nPC    = vq[i].npc;
      in_IR     = vq[i].ir;
      out_ready = vq[i].ordy;
      @(posedge clk);
      #1;
      chk("count",     i, 64'(count),     64'(vq[i].e_cnt));
      chk("out_valid", i, 64'(out_valid), 64'(vq[i].e_ov));
      chk("in_ready",  i, 64'(in_ready),  64'(vq[i].e_irdy));
      chk("out_nPC",   i, out_nPC,        vq[i].e_npc);
      chk("out_IR",    i, 64'(out_IR),    64'(vq[i].e_ir));
    end

    // full with pop requested: in_ready must stay low until after the edge
    @(negedge clk);
    in_valid = 1'b1; in_nPC = 64'h9000; in_IR = 32'hF0000000; out_ready = 1'b1;
    #1;
    chk("full_ready_no_bypass", 900, 64'(in_ready), 64'(0));
    chk("full_head",            900, 64'(out_IR),   64'(32'hE0000000));
    @(posedge clk);
    #1;
    chk("after_pop_count", 901, 64'(count),    64'(3));
    chk("after_pop_ready", 901, 64'(in_ready), 64'(1));
    chk("after_pop_head",  901, out_nPC,       64'h8004);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("flush_count", 902, 64'(count),     64'(0));
    chk("flush_valid", 902, 64'(out_valid), 64'(0));
    chk("flush_ir",    902, 64'(out_IR),    64'(0));
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
